// File: rtl/dmem_access_unit_if.sv
// Word-aligned data-memory request bus between the load/store unit (master) and memory (slave).
interface dmem_access_unit_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// RV32I memory-stage load/store unit: aligns requests onto a word bus, extends load data,
// and stalls the pipeline while an access is outstanding.
module dmem_access_unit (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  input  logic                 st_valid,
  input  logic [1:0]           size,
  input  logic                 unsigned_ld,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [4:0]           rd_idx,
  dmem_access_unit_if.master   bus,
  output logic                 stall,
  output logic                 wb_valid,
  output logic [31:0]          wb_data,
  output logic [4:0]           wb_rd,
  output logic                 st_done,
  output logic                 misalign_err
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_d;
  logic              req_d, wb_valid_d, st_done_d;
  logic              req_any, illegal, accept, ack_hit;
  logic [1:0]        lane_q, size_q;
  logic              unsigned_q, is_store_q;
  logic [REG_W-1:0]  rd_q;
  logic [3:0]        strb_c;
  logic [DATA_W-1:0] rep_c;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  // Request legality; rst_n gating keeps stall/misalign_err low while held in reset.
  always_comb begin
    req_any      = ld_valid | st_valid;
    illegal      = (ld_valid & st_valid)
                 | (size == 2'b11)
                 | ((size == SZ_HALF) & addr[0])
                 | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
    accept       = rst_n & (state == IDLE) & req_any & ~illegal;
    misalign_err = rst_n & (state == IDLE) & req_any & illegal;
    stall        = accept | (state == REQ);
    ack_hit      = (state == REQ) & bus.mem_ack;
  end

  // Store strobe generation and lane replication.
  always_comb begin
    strb_c = 4'b1111;
    rep_c  = wdata;
    case (size)
      SZ_BYTE: begin
        strb_c = 4'(4'b0001 << addr[1:0]);
        rep_c  = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        strb_c = 4'(4'b0011 << {addr[1], 1'b0});
        rep_c  = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: ld_ext = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // Next-state and registered control outputs.
  always_comb begin
    state_d    = state;
    req_d      = 1'b0;
    wb_valid_d = 1'b0;
    st_done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (bus.mem_ack) begin
          state_d    = DONE;
          req_d      = 1'b0;
          wb_valid_d = ~is_store_q;
          st_done_d  = is_store_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.mem_req <= 1'b0;
      wb_valid    <= 1'b0;
      st_done     <= 1'b0;
    end else begin
      state       <= state_d;
      bus.mem_req <= req_d;
      wb_valid    <= wb_valid_d;
      st_done     <= st_done_d;
    end
  end

  // Request capture on accept; held stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q        <= 2'b00;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      is_store_q    <= 1'b0;
      rd_q          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wstrb <= '0;
      bus.mem_wdata <= '0;
    end else if (accept) begin
      lane_q        <= addr[1:0];
      size_q        <= size;
      unsigned_q    <= unsigned_ld;
      is_store_q    <= st_valid;
      rd_q          <= rd_idx;
      bus.mem_we    <= st_valid;
      bus.mem_addr  <= {addr[31:2], 2'b00};
      bus.mem_wstrb <= st_valid ? strb_c : 4'b0000;
      bus.mem_wdata <= st_valid ? rep_c : '0;
    end
  end

  // Writeback result; holds until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data <= '0;
      wb_rd   <= '0;
    end else if (ack_hit && !is_store_q) begin
      wb_data <= ld_ext;
      wb_rd   <= rd_q;
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, wait states, illegal requests and reset abort.
module tb_dmem_access_unit;
  logic        clk;
  logic        rst_n;
  logic        ld_valid, st_valid, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_idx;
  logic        stall, wb_valid, st_done, misalign_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int errors = 0;
  int checks = 0;

  dmem_access_unit_if bus ();

  dmem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .st_valid     (st_valid),
    .size         (size),
    .unsigned_ld  (unsigned_ld),
    .addr         (addr),
    .wdata        (wdata),
    .rd_idx       (rd_idx),
    .bus          (bus.master),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .st_done      (st_done),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One legal access from request to the cycle after DONE; called just after a falling edge.
  task automatic run_access(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                            input logic [31:0] e_addr, input logic [3:0] e_strb,
                            input logic [31:0] e_wdata, input logic [31:0] e_wb);
    ld_valid = ld; st_valid = st; size = sz; unsigned_ld = uns;
    addr = a; wdata = wd; rd_idx = rd;
    #1;
    chk(tag, "stall_c0", stall, 1);
    chk(tag, "misalign_c0", misalign_err, 0);
    chk(tag, "req_c0", bus.mem_req, 0);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      chk(tag, "req", bus.mem_req, 1);
      chk(tag, "addr", bus.mem_addr, e_addr);
      chk(tag, "we", bus.mem_we, st);
      chk(tag, "wstrb", bus.mem_wstrb, e_strb);
      chk(tag, "wdata", bus.mem_wdata, e_wdata);
      chk(tag, "stall_req", stall, 1);
      chk(tag, "early_done", wb_valid | st_done, 0);
      bus.mem_ack   = (i == delay);
      bus.mem_rdata = (i == delay) ? rdata : 32'hA5A5_5A5A;
    end
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    chk(tag, "req_done", bus.mem_req, 0);
    chk(tag, "stall_done", stall, 0);
    chk(tag, "wb_valid", wb_valid, ld);
    chk(tag, "st_done", st_done, st);
    if (ld) begin
      chk(tag, "wb_data", wb_data, e_wb);
      chk(tag, "wb_rd", wb_rd, rd);
    end
    @(negedge clk);
    ld_valid = 1'b0; st_valid = 1'b0;
    chk(tag, "pulse_end", wb_valid | st_done, 0);
  endtask

  // Illegal request: flagged, no stall, no memory request, unit stays idle.
  task automatic run_illegal(input string tag, input logic ld, input logic st,
                             input logic [1:0] sz, input logic [31:0] a);
    ld_valid = ld; st_valid = st; size = sz; addr = a; unsigned_ld = 1'b0; wdata = 32'hFFFF_FFFF;
    #1;
    chk(tag, "misalign", misalign_err, 1);
    chk(tag, "stall", stall, 0);
    @(negedge clk);
    chk(tag, "req", bus.mem_req, 0);
    chk(tag, "still_idle", misalign_err, 1);
    ld_valid = 1'b0; st_valid = 1'b0;
    @(negedge clk);
    chk(tag, "req_after", bus.mem_req, 0);
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; st_valid = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0; rd_idx = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset", "req", bus.mem_req, 0);
    chk("reset", "we", bus.mem_we, 0);
    chk("reset", "addr", bus.mem_addr, 0);
    chk("reset", "wstrb", bus.mem_wstrb, 0);
    chk("reset", "wdata", bus.mem_wdata, 0);
    chk("reset", "stall", stall, 0);
    chk("reset", "wb_valid", wb_valid, 0);
    chk("reset", "st_done", st_done, 0);
    chk("reset", "wb_data", wb_data, 0);
    chk("reset", "wb_rd", wb_rd, 0);
    chk("reset", "misalign", misalign_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_access("lw_100",  1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd5,  32'hDEAD_BEEF, 0,
               32'h100, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    run_access("lb_103",  1, 0, 2'b00, 0, 32'h103, 32'h0, 5'd6,  32'h80FF_0000, 0,
               32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    run_access("lbu_103", 1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd7,  32'h80FF_0000, 0,
               32'h100, 4'b0000, 32'h0, 32'h0000_0080);
    run_access("lh_102",  1, 0, 2'b01, 0, 32'h102, 32'h0, 5'd8,  32'h80FF_0000, 1,
               32'h100, 4'b0000, 32'h0, 32'hFFFF_80FF);
    run_access("lhu_100", 1, 0, 2'b01, 1, 32'h100, 32'h0, 5'd9,  32'h1234_8001, 0,
               32'h100, 4'b0000, 32'h0, 32'h0000_8001);
    run_access("lb_pos",  1, 0, 2'b00, 0, 32'h100, 32'h0, 5'd10, 32'hFFFF_FF7F, 0,
               32'h100, 4'b0000, 32'h0, 32'h0000_007F);

    run_access("sb_201", 0, 1, 2'b00, 0, 32'h201, 32'h1234_5678, 5'd0, 32'h0, 0,
               32'h200, 4'b0010, 32'h7878_7878, 32'h0);
    chk("sb_201", "wb_data_hold", wb_data, 32'h0000_007F);
    chk("sb_201", "wb_rd_hold", wb_rd, 5'd10);
    run_access("sh_202", 0, 1, 2'b01, 0, 32'h202, 32'h1234_5678, 5'd0, 32'h0, 0,
               32'h200, 4'b1100, 32'h5678_5678, 32'h0);
    run_access("sw_dly", 0, 1, 2'b10, 0, 32'h204, 32'hCAFE_F00D, 5'd0, 32'h0, 4,
               32'h204, 4'b1111, 32'hCAFE_F00D, 32'h0);

    run_illegal("lh_101",  1, 0, 2'b01, 32'h101);
    run_illegal("lw_102",  1, 0, 2'b10, 32'h102);
    run_illegal("size_11", 1, 0, 2'b11, 32'h100);
    run_illegal("both",    1, 1, 2'b10, 32'h100);

    // Stray ack while idle must not produce a completion.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("idle_ack", "wb_valid", wb_valid, 0);
    chk("idle_ack", "st_done", st_done, 0);
    chk("idle_ack", "req", bus.mem_req, 0);
    chk("idle_ack", "wb_data", wb_data, 32'h0000_007F);

    // Reset while a store is outstanding.
    st_valid = 1'b1; size = 2'b10; addr = 32'h300; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("rst_mid", "req_before", bus.mem_req, 1);
    chk("rst_mid", "wstrb_before", bus.mem_wstrb, 4'b1111);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "req", bus.mem_req, 0);
    chk("rst_mid", "stall", stall, 0);
    chk("rst_mid", "wstrb", bus.mem_wstrb, 0);
    st_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid", "idle_req", bus.mem_req, 0);
    chk("rst_mid", "no_done", st_done, 0);
    run_access("lw_after_rst", 1, 0, 2'b10, 0, 32'h400, 32'h0, 5'd3, 32'h0123_4567, 0,
               32'h400, 4'b0000, 32'h0, 32'h0123_4567);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
